// File: rtl/tpu_host_seq.sv
// Host-side sequencer for the tpuv1 slave port: streams A/B rows onto the bus,
// triggers MatMul, then reads C back one half-row at a time onto an output stream.
module tpu_host_seq #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8,
  parameter int ADDRW   = 16,
  parameter int DATAW   = 64,
  parameter int RD_LAT  = 1,
  parameter int MM_WAIT = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic             tpu_r_w,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_wdata,
  input  logic [DATAW-1:0] tpu_rdata
);

  localparam int IW = $clog2(2 * DIM);
  localparam int TW = $clog2(MM_WAIT + RD_LAT + 2);

  // Row and half-row byte strides follow from the element widths (8 bytes each).
  localparam logic [ADDRW-1:0] AB_STRIDE = ADDRW'(DIM * BITS_AB / 8);
  localparam logic [ADDRW-1:0] C_STRIDE  = ADDRW'(DIM * BITS_C / 16);

  localparam logic [ADDRW-1:0] A_BASE  = ADDRW'(32'h0100);
  localparam logic [ADDRW-1:0] B_BASE  = ADDRW'(32'h0200);
  localparam logic [ADDRW-1:0] C_BASE  = ADDRW'(32'h0300);
  localparam logic [ADDRW-1:0] MM_ADDR = ADDRW'(32'h0400);

  localparam logic [IW-1:0] LAST_ROW  = IW'(DIM - 1);
  localparam logic [IW-1:0] LAST_WORD = IW'(2 * DIM - 1);
  localparam logic [TW-1:0] MM_LOAD   = TW'(MM_WAIT - 1);
  localparam logic [TW-1:0] RD_LOAD   = TW'(RD_LAT);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_MM,
    S_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_HOLD
  } state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    cnt, cnt_nx;
  logic [TW-1:0]    timer, timer_nx;
  logic             busy_nx, done_nx, out_valid_nx;
  logic [DATAW-1:0] out_data_nx;
  logic             r_w_nx;
  logic [ADDRW-1:0] addr_nx;
  logic [DATAW-1:0] wdata_nx;
  logic [ADDRW-1:0] ab_off, c_off;

  // cnt is the row index while loading and the C half-row index while reading.
  assign ab_off   = ADDRW'(cnt) * AB_STRIDE;
  assign c_off    = ADDRW'(cnt) * C_STRIDE;
  assign in_ready = (state == S_LOAD_A) || (state == S_LOAD_B);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      timer     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      tpu_r_w   <= 1'b0;
      tpu_addr  <= '0;
      tpu_wdata <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      timer     <= timer_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
      tpu_r_w   <= r_w_nx;
      tpu_addr  <= addr_nx;
      tpu_wdata <= wdata_nx;
    end
  end

  // Bus signals are registered, so every transfer lands on the bus one cycle
  // after the state that decides it; the bus idles whenever nothing is chosen.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    timer_nx     = timer;
    busy_nx      = busy;
    done_nx      = 1'b0;
    out_valid_nx = out_valid;
    out_data_nx  = out_data;
    r_w_nx       = 1'b0;
    addr_nx      = '0;
    wdata_nx     = '0;

    case (state)
      S_IDLE: begin
        // done is high in the first idle cycle; a start there is dropped.
        if (start && !done) begin
          state_nx = S_LOAD_A;
          busy_nx  = 1'b1;
          cnt_nx   = '0;
        end
      end

      S_LOAD_A: begin
        if (in_valid) begin
          r_w_nx   = 1'b1;
          addr_nx  = A_BASE + ab_off;
          wdata_nx = in_data;
          if (cnt == LAST_ROW) begin
            cnt_nx   = '0;
            state_nx = S_LOAD_B;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end

      S_LOAD_B: begin
        if (in_valid) begin
          r_w_nx   = 1'b1;
          addr_nx  = B_BASE + ab_off;
          wdata_nx = in_data;
          if (cnt == LAST_ROW) begin
            cnt_nx   = '0;
            state_nx = S_MM;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end

      S_MM: begin
        // The trigger write occupies the first WAIT cycle, so WAIT lasts
        // MM_WAIT-1 cycles and the first read lands MM_WAIT cycles later.
        r_w_nx   = 1'b1;
        addr_nx  = MM_ADDR;
        cnt_nx   = '0;
        timer_nx = MM_LOAD;
        state_nx = (MM_WAIT == 1) ? S_RD_ISSUE : S_WAIT;
      end

      S_WAIT: begin
        if (timer <= TIMER_ONE) begin
          timer_nx = '0;
          state_nx = S_RD_ISSUE;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end

      S_RD_ISSUE: begin
        addr_nx  = C_BASE + c_off;
        timer_nx = RD_LOAD;
        state_nx = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        // Address is on the bus in the first RD_WAIT cycle; data follows RD_LAT later.
        if (timer == '0) begin
          out_data_nx  = tpu_rdata;
          out_valid_nx = 1'b1;
          state_nx     = S_HOLD;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end

      S_HOLD: begin
        if (out_ready) begin
          out_valid_nx = 1'b0;
          if (cnt == LAST_WORD) begin
            cnt_nx   = '0;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = S_IDLE;
          end else begin
            cnt_nx   = cnt + 1'b1;
            state_nx = S_RD_ISSUE;
          end
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tpu_host_seq.sv
// Directed bench for tpu_host_seq: a model tpuv1 slave answers the bus while
// scoreboard queues hold the expected bus transfers and C words.
`timescale 1ns/1ps
module tb_tpu_host_seq;

  localparam int DIM     = 8;
  localparam int ADDRW   = 16;
  localparam int DATAW   = 64;
  localparam int RD_LAT  = 1;
  localparam int MM_WAIT = 24;
  localparam int NW      = 2 * DIM;

  localparam logic [ADDRW-1:0] A_BASE  = 16'h0100;
  localparam logic [ADDRW-1:0] B_BASE  = 16'h0200;
  localparam logic [ADDRW-1:0] C_BASE  = 16'h0300;
  localparam logic [ADDRW-1:0] MM_ADDR = 16'h0400;
  localparam logic [DATAW-1:0] JUNK    = 64'hDEAD_BEEF_DEAD_BEEF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [DATAW-1:0] in_data = '0;
  logic             busy, done, in_ready, out_valid, tpu_r_w;
  logic [DATAW-1:0] out_data, tpu_wdata, tpu_rdata;
  logic [ADDRW-1:0] tpu_addr;

  typedef struct packed {
    logic             r_w;
    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] data;
  } bus_t;

  bus_t             bus_q[$];
  logic [DATAW-1:0] out_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mm_cyc   = 0;
  int done_cnt = 0;

  logic [DATAW-1:0] job_a[DIM];
  logic [DATAW-1:0] job_b[DIM];
  logic [DATAW-1:0] m_a[DIM];
  logic [DATAW-1:0] m_b[DIM];
  logic [DATAW-1:0] m_c[NW];

  tpu_host_seq #(
    .BITS_AB(8), .BITS_C(16), .DIM(DIM), .ADDRW(ADDRW), .DATAW(DATAW),
    .RD_LAT(RD_LAT), .MM_WAIT(MM_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_wdata(tpu_wdata), .tpu_rdata(tpu_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // C = A x B with unsigned 8-bit elements and 16-bit wrapping sums; word idx is half-row idx.
  function automatic logic [DATAW-1:0] mm_word(input logic [DATAW-1:0] a[DIM],
                                               input logic [DATAW-1:0] b[DIM], input int idx);
    logic [DATAW-1:0] w;
    logic [15:0]      s;
    int               row, col;
    w   = '0;
    row = idx / 2;
    for (int j = 0; j < 4; j++) begin
      col = (idx % 2) * 4 + j;
      s   = '0;
      for (int k = 0; k < DIM; k++)
        s = s + {8'd0, a[row][8*k +: 8]} * {8'd0, b[k][8*col +: 8]};
      w[16*j +: 16] = s;
    end
    return w;
  endfunction

  // Model tpuv1 slave: registered read data, junk whenever no C read was addressed.
  always @(posedge clk) begin : model_tpu
    int ai;
    ai = int'(tpu_addr);
    tpu_rdata <= JUNK;
    if (tpu_r_w) begin
      if (ai >= 'h100 && ai < 'h100 + 8*DIM) m_a[(ai - 'h100) / 8] <= tpu_wdata;
      if (ai >= 'h200 && ai < 'h200 + 8*DIM) m_b[(ai - 'h200) / 8] <= tpu_wdata;
      if (ai == 'h400)
        for (int i = 0; i < NW; i++) m_c[i] <= mm_word(m_a, m_b, i);
    end else if (ai >= 'h300 && ai < 'h300 + 8*NW) begin
      tpu_rdata <= m_c[(ai - 'h300) / 8];
    end
  end

  task automatic check_output(input string tag, input logic [DATAW-1:0] obs,
                              input logic [DATAW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: every non-idle cycle must be the next expected transfer.
  always @(negedge clk) begin : bus_mon
    bus_t e;
    if (done === 1'b1) done_cnt++;
    if (tpu_r_w !== 1'b0 || tpu_addr !== '0) begin
      if (bus_q.size() == 0) begin
        check_output("bus_unexpected", {47'd0, tpu_r_w, tpu_addr}, '0);
      end else begin
        e = bus_q.pop_front();
        check_output("bus_r_w", 64'(tpu_r_w), 64'(e.r_w));
        check_output("bus_addr", 64'(tpu_addr), 64'(e.addr));
        check_output("bus_wdata", tpu_wdata, e.data);
        if (!e.r_w) check_output("read_while_valid", 64'(out_valid), 64'd0);
        if (e.r_w && e.addr == MM_ADDR) mm_cyc = cyc;
        if (!e.r_w && e.addr == C_BASE)
          check_output("mm_wait", 64'(cyc - mm_cyc), 64'(MM_WAIT));
      end
    end else if (tpu_wdata !== '0) begin
      check_output("idle_wdata", tpu_wdata, '0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_busy"}, 64'(busy), 64'd0);
    check_output({tag, "_done"}, 64'(done), 64'd0);
    check_output({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check_output({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check_output({tag, "_out_data"}, out_data, '0);
    check_output({tag, "_bus"}, {47'd0, tpu_r_w, tpu_addr}, '0);
    check_output({tag, "_wdata"}, tpu_wdata, '0);
  endtask

  task automatic apply_stimulus(input logic [ADDRW-1:0] base, input logic [DATAW-1:0] rows[DIM],
                                input int n, input bit gap);
    bus_t e;
    int   g;
    for (int i = 0; i < n; i++) begin
      in_data  = rows[i];
      in_valid = 1'b1;
      g = 0;
      while (in_ready !== 1'b1 && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (in_ready !== 1'b1) check_output("in_ready_timeout", 64'(in_ready), 64'd1);
      e.r_w  = 1'b1;
      e.addr = base + ADDRW'(8 * i);
      e.data = rows[i];
      bus_q.push_back(e);
      @(negedge clk);
      if (gap) begin
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic push_tail();
    bus_t e;
    e.r_w  = 1'b1;
    e.addr = MM_ADDR;
    e.data = '0;
    bus_q.push_back(e);
    for (int i = 0; i < NW; i++) begin
      e.r_w  = 1'b0;
      e.addr = C_BASE + ADDRW'(8 * i);
      bus_q.push_back(e);
      out_q.push_back(mm_word(job_a, job_b, i));
    end
  endtask

  task automatic start_job();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("start_busy", 64'(busy), 64'd1);
    check_output("start_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic consume(input int stall_word, input int stall_n, input bit start_in_done);
    int g;
    for (int w = 0; w < NW; w++) begin
      g = 0;
      while (out_valid !== 1'b1 && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (out_valid !== 1'b1) check_output("out_valid_timeout", 64'(out_valid), 64'd1);
      if (w == stall_word) begin
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          check_output("hold_valid", 64'(out_valid), 64'd1);
          check_output("hold_data", out_data, out_q[0]);
        end
      end
      out_ready = 1'b1;
      check_output("c_word", out_data, out_q.pop_front());
      @(negedge clk);
      out_ready = 1'b0;
    end
    check_output("done_pulse", 64'(done), 64'd1);
    check_output("done_busy", 64'(busy), 64'd0);
    if (start_in_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("done_clear", 64'(done), 64'd0);
    @(negedge clk);
    check_output("after_done_busy", 64'(busy), 64'd0);
  endtask

  task automatic settle(input int jobs_done);
    repeat (6) @(negedge clk);
    check_output("bus_q_drained", 64'(bus_q.size()), 64'd0);
    check_output("out_q_drained", 64'(out_q.size()), 64'd0);
    check_output("idle_busy", 64'(busy), 64'd0);
    check_output("done_count", 64'(done_cnt), 64'(jobs_done));
  endtask

  task automatic random_job();
    for (int i = 0; i < DIM; i++) begin
      job_a[i] = {$urandom, $urandom};
      job_b[i] = {$urandom, $urandom};
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] job 1: fixed rows, stall on word 3, start while busy and in done cycle");
    for (int i = 0; i < DIM; i++) begin
      job_a[i] = 64'h0101 + 64'(i);
      job_b[i] = 64'h0201 + 64'(i);
    end
    start_job();
    apply_stimulus(A_BASE, job_a, DIM, 1'b0);
    apply_stimulus(B_BASE, job_b, DIM, 1'b0);
    push_tail();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("busy_in_wait", 64'(busy), 64'd1);
    consume(3, 5, 1'b1);
    settle(1);

    $display("[TB] job 2: random rows with in_valid gaps");
    random_job();
    start_job();
    apply_stimulus(A_BASE, job_a, DIM, 1'b1);
    apply_stimulus(B_BASE, job_b, DIM, 1'b1);
    push_tail();
    consume(-1, 0, 1'b0);
    settle(2);

    $display("[TB] job 3: reset during B row 4");
    random_job();
    start_job();
    apply_stimulus(A_BASE, job_a, DIM, 1'b0);
    apply_stimulus(B_BASE, job_b, 4, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("mid_rst");
    bus_q.delete();
    out_q.delete();
    settle(2);

    $display("[TB] job 4: fresh job after reset");
    random_job();
    start_job();
    apply_stimulus(A_BASE, job_a, DIM, 1'b0);
    apply_stimulus(B_BASE, job_b, DIM, 1'b1);
    push_tail();
    consume(NW - 1, 3, 1'b0);
    settle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
